// File: rtl/and_dff_pkg.sv
// rtl/and_dff_pkg.sv - shared defaults for the registered AND leaf cell
//
// Purpose: holds the default operand width used by and_dff and its register
// so both files agree on it.
// Ports: none (package).
package and_dff_pkg;

  localparam int unsigned AND_DFF_DEFAULT_WIDTH = 1;

endpackage : and_dff_pkg

// File: rtl/and_dff_dff_sync_rst.sv
// rtl/and_dff_dff_sync_rst.sv - D register with synchronous active-high reset
//
// Purpose: WIDTH-bit D flip-flop; loads RST_VAL while rst is high at a rising
// edge of C, otherwise loads D. No asynchronous clear.
// Ports:
//   C    in   1      clock, rising edge
//   rst  in   1      synchronous reset, active high
//   D    in   WIDTH  data in
//   Q    out  WIDTH  registered data
module dff_sync_rst
  import and_dff_pkg::*;
#(
  parameter int unsigned           WIDTH   = AND_DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Reset outranks data; both are only looked at on the rising edge.
  always_ff @(posedge C) begin
    if (rst) begin
      Q <= RST_VAL;
    end else begin
      Q <= D;
    end
  end

endmodule : dff_sync_rst

// File: rtl/and_dff.sv
// rtl/and_dff.sv - registered bitwise 2-input AND
//
// Purpose: samples A & B on each rising edge of C and holds it on Q, giving a
// qualifier retimed to the C domain with exactly one edge of latency.
// Ports:
//   C    in   1      clock, rising edge, only clock in the block
//   rst  in   1      synchronous reset, active high
//   A    in   WIDTH  first operand
//   B    in   WIDTH  second operand
//   Q    out  WIDTH  registered A & B (RST_VAL after reset)
module and_dff
  import and_dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = AND_DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] d;

  assign d = A & B;

  // Q comes straight off the flop, so there is no combinational path to it.
  dff_sync_rst #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_reg (
    .C   (C),
    .rst (rst),
    .D   (d),
    .Q   (Q)
  );

endmodule : and_dff

// File: tb/tb_and_dff.sv
// tb/tb_and_dff.sv - directed bench for and_dff at WIDTH=1 and WIDTH=8
module tb_and_dff;

  logic       c;
  logic       rst1, a1, b1, q1;
  logic       rst8;
  logic [7:0] a8, b8, q8;

  int checks = 0;
  int errors = 0;

  and_dff #(.WIDTH(1)) u_w1 (
    .C(c), .rst(rst1), .A(a1), .B(b1), .Q(q1)
  );

  and_dff #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .C(c), .rst(rst8), .A(a8), .B(b8), .Q(q8)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  initial begin
    logic [1:0] tt_in [4];
    logic       tt_q  [4];
    tt_in[0] = 2'b00; tt_q[0] = 1'b0;
    tt_in[1] = 2'b01; tt_q[1] = 1'b0;
    tt_in[2] = 2'b10; tt_q[2] = 1'b0;
    tt_in[3] = 2'b11; tt_q[3] = 1'b1;

    // reset with all-ones data, and 8-bit AND
    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    rst8 = 1'b0; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    check("reset_q", {7'd0, q1}, 8'h00);
    check("w8_and", q8, 8'h30);

    @(negedge c);
    rst1 = 1'b0;
    rst8 = 1'b1;
    tick();
    check("reset_release", {7'd0, q1}, 8'h01);
    check("w8_reset", q8, 8'hA5);

    // truth table: inputs set while C low
    @(negedge c);
    rst8 = 1'b0; a8 = 8'hFF; b8 = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge c);
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      tick();
      check($sformatf("truth_%0d", i), {7'd0, q1}, {7'd0, tt_q[i]});
    end
    check("w8_release", q8, 8'h0F);

    // hold while C high and while C low
    @(negedge c);
    a1 = 1'b1; b1 = 1'b1;
    tick();
    check("hold_pre", {7'd0, q1}, 8'h01);
    #1;
    a1 = 1'b0; b1 = 1'b0;
    #1;
    check("hold_high", {7'd0, q1}, 8'h01);
    @(negedge c);
    #1;
    a1 = 1'b1; b1 = 1'b0;
    #1;
    check("hold_low", {7'd0, q1}, 8'h01);
    tick();
    check("hold_post", {7'd0, q1}, 8'h00);

    // reset priority mid-run
    @(negedge c);
    a1 = 1'b1; b1 = 1'b1;
    tick();
    check("prio_pre", {7'd0, q1}, 8'h01);
    @(negedge c);
    rst1 = 1'b1;
    tick();
    check("prio_reset", {7'd0, q1}, 8'h00);
    @(negedge c);
    rst1 = 1'b0;
    tick();
    check("prio_release", {7'd0, q1}, 8'h01);

    // latency: change just after an edge
    a1 = 1'b0;
    a8 = 8'h55; b8 = 8'hFF;
    #2;
    check("lat_hold", {7'd0, q1}, 8'h01);
    check("lat_hold_w8", q8, 8'h0F);
    tick();
    check("lat_update", {7'd0, q1}, 8'h00);
    check("lat_update_w8", q8, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_and_dff
